// File: rtl/ctrl_pipe.sv
// Control-bit pipeline ID->EX->MEM->WB with load-use bubble insertion, branch squash and HALT drain.
// Optional bubble counters are built only when CTRL_PIPE_PERF_EN is defined.
`timescale 1ns/1ps
module ctrl_pipe #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_ALUSrc,
  input  logic            id_MemtoReg,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            id_Branch,
  input  logic            id_JalrSel,
  input  logic            id_JmpSel,
  input  logic            id_halt,
  input  logic [1:0]      id_ALUOp,
  input  logic [RA_W-1:0] id_rd,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            flush,
  output logic            ex_ALUSrc,
  output logic            ex_Branch,
  output logic            ex_JalrSel,
  output logic            ex_JmpSel,
  output logic [1:0]      ex_ALUOp,
  output logic            mem_MemRead,
  output logic            mem_MemWrite,
  output logic            wb_RegWrite,
  output logic            wb_MemtoReg,
  output logic [RA_W-1:0] ex_rd,
  output logic [RA_W-1:0] mem_rd,
  output logic [RA_W-1:0] wb_rd,
  output logic            stall,
  output logic            pc_hold,
  output logic            halted
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // EX stage registers
  logic            alu_src_p0;
  logic [1:0]      alu_op_p0;
  logic            branch_p0;
  logic            jalr_sel_p0;
  logic            jmp_sel_p0;
  logic            mem_read_p0;
  logic            mem_write_p0;
  logic            reg_write_p0;
  logic            memto_reg_p0;
  logic            halt_p0;
  logic [RA_W-1:0] rd_p0;

  // MEM stage registers
  logic            mem_read_p1;
  logic            mem_write_p1;
  logic            reg_write_p1;
  logic            memto_reg_p1;
  logic            halt_p1;
  logic [RA_W-1:0] rd_p1;

  // WB stage registers
  logic            reg_write_p2;
  logic            memto_reg_p2;
  logic            halt_p2;
  logic [RA_W-1:0] rd_p2;

  logic            halted_q;
  logic            hazard;
  logic            bubble;

  // Load in EX whose destination is a source of the ID instruction; x0 is never a real dependency.
  assign hazard  = mem_read_p0 & (rd_p0 != '0) & ((rd_p0 == id_rs1) | (rd_p0 == id_rs2));
  assign stall   = hazard & ~flush;
  assign pc_hold = halt_p0 | halt_p1 | halt_p2 | halted_q;
  assign bubble  = flush | stall | pc_hold;

  // ID -> EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_src_p0   <= 1'b0;
      alu_op_p0    <= 2'b00;
      branch_p0    <= 1'b0;
      jalr_sel_p0  <= 1'b0;
      jmp_sel_p0   <= 1'b0;
      mem_read_p0  <= 1'b0;
      mem_write_p0 <= 1'b0;
      reg_write_p0 <= 1'b0;
      memto_reg_p0 <= 1'b0;
      halt_p0      <= 1'b0;
      rd_p0        <= '0;
    end else if (bubble) begin
      alu_src_p0   <= 1'b0;
      alu_op_p0    <= 2'b00;
      branch_p0    <= 1'b0;
      jalr_sel_p0  <= 1'b0;
      jmp_sel_p0   <= 1'b0;
      mem_read_p0  <= 1'b0;
      mem_write_p0 <= 1'b0;
      reg_write_p0 <= 1'b0;
      memto_reg_p0 <= 1'b0;
      halt_p0      <= 1'b0;
      rd_p0        <= '0;
    end else begin
      alu_src_p0   <= id_ALUSrc;
      alu_op_p0    <= id_ALUOp;
      branch_p0    <= id_Branch;
      jalr_sel_p0  <= id_JalrSel;
      jmp_sel_p0   <= id_JmpSel;
      mem_read_p0  <= id_MemRead;
      mem_write_p0 <= id_MemWrite;
      reg_write_p0 <= id_RegWrite;
      memto_reg_p0 <= id_MemtoReg;
      halt_p0      <= id_halt;
      rd_p0        <= id_rd;
    end
  end

  // EX -> MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      reg_write_p1 <= 1'b0;
      memto_reg_p1 <= 1'b0;
      halt_p1      <= 1'b0;
      rd_p1        <= '0;
    end else begin
      mem_read_p1  <= mem_read_p0;
      mem_write_p1 <= mem_write_p0;
      reg_write_p1 <= reg_write_p0;
      memto_reg_p1 <= memto_reg_p0;
      halt_p1      <= halt_p0;
      rd_p1        <= rd_p0;
    end
  end

  // MEM -> WB; halted latches on the same edge that moves HALT into WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_p2 <= 1'b0;
      memto_reg_p2 <= 1'b0;
      halt_p2      <= 1'b0;
      rd_p2        <= '0;
      halted_q     <= 1'b0;
    end else begin
      reg_write_p2 <= reg_write_p1;
      memto_reg_p2 <= memto_reg_p1;
      halt_p2      <= halt_p1;
      rd_p2        <= rd_p1;
      halted_q     <= halted_q | halt_p1;
    end
  end

  assign ex_ALUSrc    = alu_src_p0;
  assign ex_ALUOp     = alu_op_p0;
  assign ex_Branch    = branch_p0;
  assign ex_JalrSel   = jalr_sel_p0;
  assign ex_JmpSel    = jmp_sel_p0;
  assign ex_rd        = rd_p0;
  assign mem_MemRead  = mem_read_p1;
  assign mem_MemWrite = mem_write_p1;
  assign mem_rd       = rd_p1;
  assign wb_RegWrite  = reg_write_p2;
  assign wb_MemtoReg  = memto_reg_p2;
  assign wb_rd        = rd_p2;
  assign halted       = halted_q;

`ifdef CTRL_PIPE_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return (&v) ? v : v + one;
  endfunction

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Counters freeze once the core has halted so the final values can be read out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!halted_q) begin
      if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: vector table for per-cycle stage contents plus hand sequences
// for reset, flush-with-halt, HALT drain and (with CTRL_PIPE_PERF_EN) the bubble counters.
`timescale 1ns/1ps
module tb_ctrl_pipe;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic clk, rst_n;
  logic id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite;
  logic id_Branch, id_JalrSel, id_JmpSel, id_halt;
  logic [1:0] id_ALUOp;
  logic [RA_W-1:0] id_rd, id_rs1, id_rs2;
  logic flush;
  logic ex_ALUSrc, ex_Branch, ex_JalrSel, ex_JmpSel;
  logic [1:0] ex_ALUOp;
  logic mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg;
  logic [RA_W-1:0] ex_rd, mem_rd, wb_rd;
  logic stall, pc_hold, halted;
`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [CNT_W-1:0] flush_snap;
`endif

  int checks = 0;
  int errors = 0;

  ctrl_pipe #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
    .id_JalrSel(id_JalrSel), .id_JmpSel(id_JmpSel), .id_halt(id_halt),
    .id_ALUOp(id_ALUOp), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .flush(flush),
    .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch), .ex_JalrSel(ex_JalrSel),
    .ex_JmpSel(ex_JmpSel), .ex_ALUOp(ex_ALUOp),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .stall(stall), .pc_hold(pc_hold), .halted(halted)
`ifdef CTRL_PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ctl = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JalrSel, JmpSel, halt}
  // ex  = {ALUSrc, ALUOp, Branch, JalrSel, JmpSel, rd}; mem = {MemRead, MemWrite, rd}; wb = {RegWrite, MemtoReg, rd}
  typedef struct {
    logic [8:0]  ctl;
    logic [1:0]  aluop;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fl;
    logic        stl;
    logic [10:0] ex;
    logic [6:0]  mem;
    logic [6:0]  wb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [8:0] ctl, input logic [1:0] aluop, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic fl);
    {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite,
     id_Branch, id_JalrSel, id_JmpSel, id_halt} = ctl;
    id_ALUOp = aluop;
    id_rd    = rd;
    id_rs1   = rs1;
    id_rs2   = rs2;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ex_obs();
    return 32'({ex_ALUSrc, ex_ALUOp, ex_Branch, ex_JalrSel, ex_JmpSel, ex_rd});
  endfunction
  function automatic logic [31:0] mem_obs();
    return 32'({mem_MemRead, mem_MemWrite, mem_rd});
  endfunction
  function automatic logic [31:0] wb_obs();
    return 32'({wb_RegWrite, wb_MemtoReg, wb_rd});
  endfunction
  function automatic logic [31:0] all_obs();
    return 32'({ex_obs()[10:0], mem_obs()[6:0], wb_obs()[6:0], stall, pc_hold, halted});
  endfunction

  initial begin
    vecs[0]  = '{9'b001000000, 2'b10, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 11'b0_10_000_00101, 7'b00_00000, 7'b00_00000};
    vecs[1]  = '{9'b111100000, 2'b00, 5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 11'b1_00_000_00111, 7'b00_00101, 7'b00_00000};
    vecs[2]  = '{9'b001000000, 2'b10, 5'd8, 5'd4, 5'd7, 1'b0, 1'b1, 11'b0_00_000_00000, 7'b10_00111, 7'b10_00101};
    vecs[3]  = '{9'b001000000, 2'b10, 5'd8, 5'd4, 5'd7, 1'b0, 1'b0, 11'b0_10_000_01000, 7'b00_00000, 7'b11_00111};
    vecs[4]  = '{9'b100010000, 2'b00, 5'd0, 5'd8, 5'd9, 1'b0, 1'b0, 11'b1_00_000_00000, 7'b00_01000, 7'b00_00000};
    vecs[5]  = '{9'b111100000, 2'b00, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 11'b1_00_000_00000, 7'b01_00000, 7'b10_01000};
    vecs[6]  = '{9'b001000000, 2'b10, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 11'b0_10_000_00011, 7'b10_00000, 7'b00_00000};
    vecs[7]  = '{9'b000001000, 2'b01, 5'd0, 5'd3, 5'd4, 1'b0, 1'b0, 11'b0_01_100_00000, 7'b00_00011, 7'b11_00000};
    vecs[8]  = '{9'b001000010, 2'b00, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 11'b0_00_000_00000, 7'b00_00000, 7'b10_00011};
    vecs[9]  = '{9'b101000100, 2'b00, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 11'b1_00_010_00001, 7'b00_00000, 7'b00_00000};
    vecs[10] = '{9'b111100000, 2'b00, 5'd6, 5'd1, 5'd0, 1'b0, 1'b0, 11'b1_00_000_00110, 7'b00_00001, 7'b00_00000};
    vecs[11] = '{9'b001000000, 2'b10, 5'd2, 5'd6, 5'd0, 1'b1, 1'b0, 11'b0_00_000_00000, 7'b10_00110, 7'b10_00001};

    rst_n = 1'b0;
    drive(9'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    #12;
    chk("reset_state", all_obs(), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ctl, vecs[i].aluop, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].fl);
      #1;
      chk($sformatf("row%0d_stall", i), 32'(stall), 32'(vecs[i].stl));
      tick();
      chk($sformatf("row%0d_ex", i), ex_obs(), 32'(vecs[i].ex));
      chk($sformatf("row%0d_mem", i), mem_obs(), 32'(vecs[i].mem));
      chk($sformatf("row%0d_wb", i), wb_obs(), 32'(vecs[i].wb));
    end
`ifdef CTRL_PIPE_PERF_EN
    chk("stall_cnt_after_table", 32'(stall_cnt), 32'd1);
    chk("flush_cnt_after_table", 32'(flush_cnt), 32'd2);
`endif

    // Asynchronous reset in the middle of a clock period with live stages
    drive(9'b001000000, 2'b10, 5'd5, 5'd1, 5'd2, 1'b0);
    tick();
    chk("pre_reset_ex", ex_obs(), 32'(11'b0_10_000_00101));
    drive(9'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_all", all_obs(), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
    chk("async_reset_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
`endif
    #3 rst_n = 1'b1;
    tick();

    // Flush squashes a wrong-path store+HALT in ID
    drive(9'b000010001, 2'b00, 5'd4, 5'd1, 5'd2, 1'b1);
    #1;
    chk("flush_pre_hold", 32'(pc_hold), 32'd0);
    tick();
    chk("flush_ex_bubble", ex_obs(), 32'd0);
    chk("flush_no_halt", 32'(pc_hold), 32'd0);
    drive(9'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("flush_halted", 32'({mem_MemWrite, halted, pc_hold}), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
    chk("flush_cnt_plus1", 32'(flush_cnt), 32'd1);
`endif

    // HALT then a younger add: add never enters EX, halted after three edges
    drive(9'b000000001, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("halt_pre_hold", 32'(pc_hold), 32'd0);
    tick();
    chk("halt_in_ex_hold", 32'(pc_hold), 32'd1);
    drive(9'b001000000, 2'b10, 5'd9, 5'd1, 5'd2, 1'b0);
    tick();
    chk("halt_add_blocked", ex_obs(), 32'd0);
    chk("halt_not_yet_2", 32'(halted), 32'd0);
    tick();
    chk("halt_set_3", 32'(halted), 32'd1);
    chk("halt_wb_clean", wb_obs(), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
    flush_snap = flush_cnt;
`endif
    for (int i = 0; i < 10; i++) begin
      flush = (i < 3);
      tick();
    end
    flush = 1'b0;
    chk("halt_sticky", 32'({halted, pc_hold}), 32'd3);
    chk("halt_frozen_ex", ex_obs(), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
    chk("cnt_hold_halted", 32'(flush_cnt), 32'(flush_snap));
`endif

    // Reset clears the sticky halt
    #2 rst_n = 1'b0;
    #1;
    chk("reset_clears_halt", 32'({halted, pc_hold}), 32'd0);
    #3 rst_n = 1'b1;
    tick();

`ifdef CTRL_PIPE_PERF_EN
    drive(9'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    flush = 1'b0;
    chk("flush_cnt_saturate", 32'(flush_cnt), 32'hF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
